// File: rtl/mmio_responder.sv
// mmio_responder: small MMIO register block behind a valid/ready request port.
// Latency: rsp_valid rises LAT cycles after the request is accepted; one request in flight.
// Backpressure: rsp_valid/rsp_data/rsp_err hold until rsp_ready; req_ready is low until the response handshake.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   req_valid/req_ready           request handshake; req_addr, req_we, req_wdata, req_wmask carry the request
//   rsp_valid/rsp_ready           response handshake; rsp_data (0 for writes/errors), rsp_err
//   tohost                        live value of the TOHOST register
//
// Register map (word offset req_addr[4:0], MMIO range req_addr[AW-1:AW-2] == 2'b01):
//   0x00 SCRATCH0 RW, 0x04 SCRATCH1 RW, 0x08 TOHOST RW, 0x0C STATUS RO,
//   0x10 TIMER_LO RO, 0x14 TIMER_HI RO (timer registers only when MMIO_TIMER_EN is defined)
//
// Build option: define MMIO_TIMER_EN to include a free-running 64-bit timer. AW must be >= 8.

module mmio_responder #(
    parameter int AW  = 16,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    input  logic          req_we,
    input  logic [3:0]    req_wmask,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_data,
    output logic          rsp_err,
    output logic [31:0]   tohost
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // The WAIT counter is loaded with LAT-2 so WAIT lasts LAT-1 cycles.
    localparam logic [2:0] CNT_INIT = (LAT >= 2) ? 3'(LAT - 2) : 3'd0;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    logic [31:0] scratch0_q, scratch1_q, tohost_q;
    logic [15:0] status_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;

`ifdef MMIO_TIMER_EN
    logic [63:0] timer_q;
    logic [31:0] snap_q;
`endif

    logic        accept;
    logic [2:0]  off;
    logic        in_range, aligned, upper_zero;
    logic        known, ro;
    logic        dec_err;
    logic        wr_ok;
    logic [31:0] rd_val;

    assign accept     = req_valid && req_ready;
    assign off        = req_addr[4:2];
    assign in_range   = (req_addr[AW-1:AW-2] == 2'b01);
    assign aligned    = (req_addr[1:0] == 2'b00);
    assign upper_zero = (req_addr[AW-3:5] == '0);

    // Offset decode: which word offsets exist and which are read-only.
    always_comb begin
        known = 1'b0;
        ro    = 1'b0;
        case (off)
            3'd0, 3'd1, 3'd2: known = 1'b1;
            3'd3: begin
                known = 1'b1;
                ro    = 1'b1;
            end
`ifdef MMIO_TIMER_EN
            3'd4, 3'd5: begin
                known = 1'b1;
                ro    = 1'b1;
            end
`endif
            default: begin
                known = 1'b0;
                ro    = 1'b0;
            end
        endcase
    end

    // Any error leaves all registers except STATUS untouched.
    assign dec_err = !(in_range && aligned && upper_zero && known) || (req_we && ro);
    assign wr_ok   = accept && req_we && !dec_err;

    // STATUS reads back the count including the request doing the read.
    always_comb begin
        rd_val = '0;
        case (off)
            3'd0: rd_val = scratch0_q;
            3'd1: rd_val = scratch1_q;
            3'd2: rd_val = tohost_q;
            3'd3: rd_val = {16'h0000, status_q + 16'd1};
`ifdef MMIO_TIMER_EN
            3'd4: rd_val = timer_q[31:0];
            3'd5: rd_val = snap_q;
`endif
            default: rd_val = '0;
        endcase
    end

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                r[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return r;
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (LAT == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Gated with rst so the port is quiet for the whole reset window,
    // including the cycle in which rst is first seen.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        if (!rst) begin
            req_ready = (state_q == S_IDLE);
            rsp_valid = (state_q == S_RESP);
            rsp_data  = rsp_data_q;
            rsp_err   = rsp_err_q;
        end
    end

    // ---------------- Registers and response capture ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            scratch0_q <= '0;
            scratch1_q <= '0;
            tohost_q   <= '0;
            status_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                status_q   <= status_q + 16'd1;
                rsp_err_q  <= dec_err;
                rsp_data_q <= (req_we || dec_err) ? 32'h0 : rd_val;
            end
            if (wr_ok && off == 3'd0) scratch0_q <= merge_lanes(scratch0_q, req_wdata, req_wmask);
            if (wr_ok && off == 3'd1) scratch1_q <= merge_lanes(scratch1_q, req_wdata, req_wmask);
            if (wr_ok && off == 3'd2) tohost_q   <= merge_lanes(tohost_q, req_wdata, req_wmask);
        end
    end

`ifdef MMIO_TIMER_EN
    // Reading TIMER_LO freezes the upper half so a following TIMER_HI read
    // forms a coherent 64-bit value.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            snap_q  <= '0;
        end else begin
            timer_q <= timer_q + 64'd1;
            if (accept && !req_we && !dec_err && off == 3'd4) begin
                snap_q <= timer_q[63:32];
            end
        end
    end
`endif

    assign tohost = tohost_q;

endmodule
